// File: rtl/info_frame_builder_if.sv
// Configuration and payload-write channel between control logic and the InfoFrame builder.
interface info_frame_builder_if;
  logic       cfg_start;
  logic [6:0] cfg_type;
  logic [7:0] cfg_version;
  logic [4:0] cfg_length;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       abort;

  modport master (
    output cfg_start, cfg_type, cfg_version, cfg_length, wr_valid, wr_data, abort,
    input  wr_ready
  );

  modport slave (
    input  cfg_start, cfg_type, cfg_version, cfg_length, wr_valid, wr_data, abort,
    output wr_ready
  );
endinterface

// File: rtl/info_frame_builder.sv
// Double-buffered HDMI InfoFrame builder: stages header/payload, computes the checksum
// on the fly and swaps the staged frame into the registered active outputs.
module info_frame_builder #(
  parameter bit          SWAP_ON_BOUNDARY = 1'b1,
  parameter int unsigned MAX_LENGTH       = 27
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  info_frame_builder_if.slave  bus,
  input  logic                 frame_boundary,
  output logic [23:0]          header,
  output logic [3:0][55:0]     sub,
  output logic                 valid,
  output logic                 busy,
  output logic                 updated,
  output logic                 error
);

  localparam logic [4:0] MAX_LEN = 5'(MAX_LENGTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  // Byte sum of the three header bytes HB0..HB2 as transmitted.
  function automatic logic [7:0] header_sum(input logic [6:0] t, input logic [7:0] v,
                                            input logic [4:0] l);
    header_sum = {1'b1, t} + v + {3'b000, l};
  endfunction

  state_t            state_q;
  logic [6:0]        type_q;
  logic [7:0]        version_q;
  logic [4:0]        length_q;
  logic [4:0]        count_q;
  logic [7:0]        acc_q;
  logic [27:0][7:0]  pb_q;
  logic [23:0]       header_q;
  logic [3:0][55:0]  sub_q;
  logic              valid_q;
  logic              busy_q;
  logic              updated_q;
  logic              error_q;
  logic              wr_ready_q;

  logic [7:0]        acc_start_d;
  logic [7:0]        acc_d;
  logic              swap_d;

  // Next accumulator values and swap permission for the current cycle.
  always_comb begin
    acc_start_d = header_sum(bus.cfg_type, bus.cfg_version, bus.cfg_length);
    acc_d       = acc_q + bus.wr_data;
    swap_d      = !SWAP_ON_BOUNDARY || frame_boundary;
  end

  // Control FSM with staging buffer, checksum accumulator and active output registers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q    <= IDLE;
      type_q     <= 7'd0;
      version_q  <= 8'd0;
      length_q   <= 5'd0;
      count_q    <= 5'd0;
      acc_q      <= 8'd0;
      pb_q       <= '0;
      header_q   <= 24'd0;
      sub_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      updated_q  <= 1'b0;
      error_q    <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      updated_q <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_start) begin
            if (bus.cfg_length > MAX_LEN) begin
              error_q <= 1'b1;
            end else begin
              type_q    <= bus.cfg_type;
              version_q <= bus.cfg_version;
              length_q  <= bus.cfg_length;
              count_q   <= 5'd1;
              acc_q     <= acc_start_d;
              pb_q      <= '0;
              busy_q    <= 1'b1;
              // An empty payload needs only the header checksum, so skip LOAD.
              if (bus.cfg_length == 5'd0) begin
                pb_q[0] <= 8'd0 - acc_start_d;
                state_q <= PENDING;
              end else begin
                state_q    <= LOAD;
                wr_ready_q <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
          end else if (bus.wr_valid) begin
            pb_q[count_q] <= bus.wr_data;
            acc_q         <= acc_d;
            count_q       <= count_q + 5'd1;
            if (count_q == length_q) begin
              pb_q[0]    <= 8'd0 - acc_d;
              state_q    <= PENDING;
              wr_ready_q <= 1'b0;
            end
          end
        end
        PENDING: begin
          // Abort takes priority over a coincident frame boundary.
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (swap_d) begin
            header_q  <= {3'b000, length_q, version_q, 1'b1, type_q};
            sub_q     <= pb_q;
            valid_q   <= 1'b1;
            updated_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign header       = header_q;
  assign sub          = sub_q;
  assign valid        = valid_q;
  assign busy         = busy_q;
  assign updated      = updated_q;
  assign error        = error_q;
  assign bus.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_info_frame_builder.sv
// Scoreboard bench: two builders (immediate swap / boundary swap) share stimulus;
// expected frames come from an arithmetic InfoFrame model.
module tb_info_frame_builder;

  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] sub;
  } frame_t;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_start = 1'b0;
  logic [6:0] cfg_type = 7'd0;
  logic [7:0] cfg_version = 8'd0;
  logic [4:0] cfg_length = 5'd0;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic abort = 1'b0;
  logic fb = 1'b0;

  logic [23:0] hdr0, hdr1;
  logic [3:0][55:0] sub0, sub1;
  logic valid0, valid1, busy0, busy1, upd0, upd1, err0, err1;

  int passed = 0;
  int total = 0;

  frame_t q0[$];
  frame_t q1[$];
  logic [23:0]  act_hdr0 = 24'd0, act_hdr1 = 24'd0;
  logic [223:0] act_sub0 = '0, act_sub1 = '0;
  logic act_valid0 = 1'b0, act_valid1 = 1'b0;

  info_frame_builder_if if0 ();
  info_frame_builder_if if1 ();

  assign if0.cfg_start = cfg_start;     assign if1.cfg_start = cfg_start;
  assign if0.cfg_type = cfg_type;       assign if1.cfg_type = cfg_type;
  assign if0.cfg_version = cfg_version; assign if1.cfg_version = cfg_version;
  assign if0.cfg_length = cfg_length;   assign if1.cfg_length = cfg_length;
  assign if0.wr_valid = wr_valid;       assign if1.wr_valid = wr_valid;
  assign if0.wr_data = wr_data;         assign if1.wr_data = wr_data;
  assign if0.abort = abort;             assign if1.abort = abort;

  info_frame_builder #(.SWAP_ON_BOUNDARY(1'b0), .MAX_LENGTH(27)) dut0 (
    .clk_pixel(clk), .reset(reset), .bus(if0.slave), .frame_boundary(fb),
    .header(hdr0), .sub(sub0), .valid(valid0), .busy(busy0), .updated(upd0), .error(err0)
  );

  info_frame_builder #(.SWAP_ON_BOUNDARY(1'b1), .MAX_LENGTH(27)) dut1 (
    .clk_pixel(clk), .reset(reset), .bus(if1.slave), .frame_boundary(fb),
    .header(hdr1), .sub(sub1), .valid(valid1), .busy(busy1), .updated(upd1), .error(err1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkw(input string name, input logic [223:0] act, input logic [223:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else passed++;
  endtask

  // InfoFrame reference: all header and payload bytes plus PB0 sum to 0 mod 256.
  function automatic frame_t model_frame(input logic [6:0] t, input logic [7:0] v,
                                         input int len, input byte_q_t pl);
    frame_t f;
    int sum;
    logic [7:0] pb [28];
    sum = 128 + int'(t) + int'(v) + len;
    for (int k = 0; k < 28; k++) pb[k] = 8'd0;
    for (int k = 0; k < len; k++) begin
      pb[k + 1] = pl[k];
      sum += int'(pl[k]);
    end
    pb[0] = 8'((256 - (sum % 256)) % 256);
    f.hdr = {3'b000, 5'(len), v, 1'b1, t};
    f.sub = '0;
    for (int k = 0; k < 28; k++) f.sub[8*k +: 8] = pb[k];
    return f;
  endfunction

  // Monitor: every updated pulse must match the oldest expected frame.
  always @(negedge clk) begin
    frame_t e;
    if (upd0) begin
      check1("upd0_expected", q0.size() != 0, 1'b1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        checkw("hdr0_swap", 224'(hdr0), 224'(e.hdr));
        checkw("sub0_swap", sub0, e.sub);
        check1("valid0_swap", valid0, 1'b1);
      end
    end
    if (upd1) begin
      check1("upd1_expected", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checkw("hdr1_swap", 224'(hdr1), 224'(e.hdr));
        checkw("sub1_swap", sub1, e.sub);
        check1("valid1_swap", valid1, 1'b1);
      end
    end
  end

  task automatic check_cleared(input string tag);
    checkw({tag, "_hdr0"}, 224'(hdr0), 224'd0);
    checkw({tag, "_sub0"}, sub0, 224'd0);
    checkw({tag, "_hdr1"}, 224'(hdr1), 224'd0);
    checkw({tag, "_sub1"}, sub1, 224'd0);
    check1({tag, "_valid0"}, valid0, 1'b0);
    check1({tag, "_valid1"}, valid1, 1'b0);
    check1({tag, "_busy0"}, busy0, 1'b0);
    check1({tag, "_busy1"}, busy1, 1'b0);
    check1({tag, "_rdy0"}, if0.wr_ready, 1'b0);
    check1({tag, "_rdy1"}, if1.wr_ready, 1'b0);
    check1({tag, "_upd0"}, upd0, 1'b0);
    check1({tag, "_err0"}, err0, 1'b0);
    check1({tag, "_err1"}, err1, 1'b0);
  endtask

  task automatic start_cfg(input logic [6:0] t, input logic [7:0] v, input int len);
    cfg_type = t;
    cfg_version = v;
    cfg_length = 5'(len);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic run_frame(input logic [6:0] t, input logic [7:0] v, input int len,
                           input byte_q_t pl, input int gap_pct, input int hold,
                           input bit abort_fb, input bit fb_in_load);
    frame_t f;
    f = model_frame(t, v, len, pl);
    start_cfg(t, v, len);
    check1("busy0_start", busy0, 1'b1);
    check1("busy1_start", busy1, 1'b1);
    check1("wr_ready_start", if0.wr_ready, len != 0);
    for (int i = 0; i < len; i++) begin
      if (fb_in_load && i == 1) begin
        // Stray boundary and cfg_start while loading: neither may have any effect.
        fb = 1'b1;
        cfg_start = 1'b1;
        cfg_length = 5'd31;
        tick();
        fb = 1'b0;
        cfg_start = 1'b0;
        check1("err0_ign_start", err0, 1'b0);
        check1("err1_ign_start", err1, 1'b0);
      end
      while ($urandom_range(99) < gap_pct) tick();
      wr_valid = 1'b1;
      wr_data = pl[i];
      tick();
      wr_valid = 1'b0;
    end
    q0.push_back(f);
    check1("upd0_early", upd0, 1'b0);
    check1("busy0_pending", busy0, 1'b1);
    tick();
    check1("upd0_latency", upd0, 1'b1);
    check1("busy0_done", busy0, 1'b0);
    act_hdr0 = f.hdr; act_sub0 = f.sub; act_valid0 = 1'b1;
    repeat (hold) tick();
    check1("busy1_hold", busy1, 1'b1);
    checkw("hdr1_hold", 224'(hdr1), 224'(act_hdr1));
    checkw("sub1_hold", sub1, act_sub1);
    fb = 1'b1;
    abort = abort_fb;
    if (!abort_fb) q1.push_back(f);
    tick();
    fb = 1'b0;
    abort = 1'b0;
    check1("upd1_boundary", upd1, !abort_fb);
    check1("busy1_boundary", busy1, 1'b0);
    if (!abort_fb) begin
      act_hdr1 = f.hdr; act_sub1 = f.sub; act_valid1 = 1'b1;
    end
    checkw("hdr0_stable", 224'(hdr0), 224'(act_hdr0));
    checkw("hdr1_after", 224'(hdr1), 224'(act_hdr1));
  endtask

  task automatic run_error(input int len);
    start_cfg(7'd3, 8'd1, len);
    check1("err0_pulse", err0, 1'b1);
    check1("err1_pulse", err1, 1'b1);
    check1("busy0_err", busy0, 1'b0);
    check1("valid0_err", valid0, act_valid0);
    check1("valid1_err", valid1, act_valid1);
    tick();
    check1("err0_one_cycle", err0, 1'b0);
    checkw("hdr0_err", 224'(hdr0), 224'(act_hdr0));
    checkw("sub1_err", sub1, act_sub1);
  endtask

  function automatic byte_q_t rand_payload(input int len);
    byte_q_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(255)));
    return p;
  endfunction

  initial begin
    byte_q_t pl;
    logic [223:0] exp_sub;
    int len;

    repeat (3) tick();
    reset = 1'b0;
    check_cleared("reset");

    // AVI frame from the datasheet example.
    pl = '{8'h02, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'd2, 8'd2, 13, pl, 0, 0, 1'b0, 1'b0);
    checkw("avi_hdr", 224'(hdr0), 224'h0D0282);
    exp_sub = 224'h00000100080264;
    checkw("avi_sub", sub0, exp_sub);
    check1("avi_valid", valid0, 1'b1);

    // Empty payload.
    pl = {};
    run_frame(7'd1, 8'd1, 0, pl, 0, 0, 1'b0, 1'b0);
    checkw("len0_hdr", 224'(hdr0), 224'h000181);
    checkw("len0_sub", sub0, 224'h7E);

    run_error(28);
    run_error(31);

    // Long hold with no boundary, then abort racing a boundary.
    run_frame(7'd4, 8'd1, 9, rand_payload(9), 20, 100, 1'b0, 1'b1);
    run_frame(7'd5, 8'd3, 6, rand_payload(6), 0, 5, 1'b1, 1'b0);

    // Long frame followed by a short one loaded with gaps.
    run_frame(7'd2, 8'd2, 13, rand_payload(13), 0, 2, 1'b0, 1'b0);
    run_frame(7'd2, 8'd2, 5, rand_payload(5), 50, 1, 1'b0, 1'b0);
    checkw("short_upper_zero", 224'(sub0[3:1]), 224'd0);

    // Abort during LOAD leaves the active frame untouched.
    start_cfg(7'd6, 8'd1, 8);
    wr_valid = 1'b1; wr_data = 8'hAA; tick();
    wr_valid = 1'b0; abort = 1'b1; tick();
    abort = 1'b0;
    check1("abort_busy0", busy0, 1'b0);
    check1("abort_busy1", busy1, 1'b0);
    check1("abort_rdy0", if0.wr_ready, 1'b0);
    fb = 1'b1; tick(); fb = 1'b0; tick();
    checkw("abort_hdr0", 224'(hdr0), 224'(act_hdr0));
    checkw("abort_sub1", sub1, act_sub1);

    // Reset in the middle of loading.
    start_cfg(7'd7, 8'd2, 10);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1); tick();
    end
    wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("midreset");
    act_hdr0 = '0; act_sub0 = '0; act_valid0 = 1'b0;
    act_hdr1 = '0; act_sub1 = '0; act_valid1 = 1'b0;
    run_frame(7'd8, 8'd4, 10, rand_payload(10), 10, 0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(27, 1));
      run_frame(7'($urandom_range(127)), 8'($urandom_range(255)), len, rand_payload(len),
                int'($urandom_range(40)), int'($urandom_range(12)),
                $urandom_range(5) == 0, $urandom_range(1) == 1);
      if ($urandom_range(3) == 0) run_error(int'($urandom_range(31, 28)));
    end

    repeat (3) tick();
    check1("q0_drained", q0.size() == 0, 1'b1);
    check1("q1_drained", q1.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/info_frame_builder.md
# info_frame_builder

Runtime-programmable HDMI InfoFrame generator: accepts type, version, length and payload bytes over a byte-wide write handshake, computes the InfoFrame checksum sequentially, and presents the finished packet as one 24-bit header and four 56-bit subpackets. Double-buffered: the packet engine always sees a complete, consistent InfoFrame; a new one replaces the active one only on a frame boundary, or immediately when configured. Sits between control logic and the HDMI packet scheduler, replacing fixed-content InfoFrame modules.

## Interface

- SWAP_ON_BOUNDARY, 1: 1 = staged frame becomes active only on `frame_boundary`; 0 = becomes active one cycle after completion.
- MAX_LENGTH, 27: largest accepted payload length in bytes (PB1..PBn); legal range 1..27.

Clock and reset: one clock `clk_pixel`; reset `reset` is synchronous, active-high.

- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous active-high reset
- cfg_start  in  1  begin new frame (sampled in IDLE only)
- cfg_type  in  7  InfoFrame type, sampled with cfg_start
- cfg_version  in  8  version, sampled with cfg_start
- cfg_length  in  5  payload byte count, sampled with cfg_start
- wr_valid  in  1  payload byte valid
- wr_data  in  8  payload byte
- wr_ready  out  1  byte accepted when wr_valid & wr_ready
- abort  in  1  discard staged frame
- frame_boundary  in  1  swap permission strobe (e.g. vsync start)
- header  out  24  active {3'b0,length}, version, {1'b1,type}
- sub  out  4x56  active subpackets; sub[i] = {PB[7i+6],...,PB[7i]}, PB[7i] in bits 7:0
- valid  out  1  at least one frame activated since reset
- busy  out  1  state != IDLE
- updated  out  1  one-cycle pulse on the cycle active buffer changes
- error  out  1  one-cycle pulse on rejected cfg_start

## Operation

- States: IDLE, LOAD, PENDING.
- IDLE: cfg_start with cfg_length > MAX_LENGTH -> error pulse next cycle, stay IDLE, nothing staged. Otherwise latch type/version/length, clear staged PB1..PB27 to 0, initialise accumulator = header byte sum mod 256; go to LOAD (length >= 1) or PENDING (length 0).
- LOAD: wr_ready = 1. k-th accepted byte (k = 1..length) written to staged PB[k], added to accumulator mod 256. Accepting byte k = length -> PENDING. wr_valid with no acceptance outside LOAD is ignored.
- Checksum: staged PB0 = (256 - final accumulator) mod 256, i.e. sum of 3 header bytes plus PB0..PBlength is 0 mod 256. Registered on entry to PENDING.
- PENDING: SWAP_ON_BOUNDARY=1 -> swap at clock edge where frame_boundary = 1; =0 -> swap on first PENDING cycle. Swap: active header/sub <= staged, valid <= 1, updated pulses, state -> IDLE.
- Bytes PB[length+1..27] always 0 in active output.
- abort in LOAD or PENDING -> IDLE next cycle, staging discarded, active unchanged, no updated pulse. abort in IDLE: no effect.
- abort and frame_boundary same cycle in PENDING: abort wins.
- cfg_start outside IDLE: ignored, no error.
- reset mid-operation: all state and active buffer cleared.

## Timing

- Reset values: header 0, sub all 0, valid 0, busy 0, wr_ready 0, updated 0, error 0; state IDLE.
- cfg_start at cycle t -> busy and (if length >= 1) wr_ready high at t+1.
- Full-rate loading: one byte per cycle; last byte at cycle u -> PENDING at u+1.
- SWAP_ON_BOUNDARY=0: outputs update at u+2; length 0: cfg_start at t -> update at t+2.
- SWAP_ON_BOUNDARY=1: frame_boundary sampled high at cycle b (in PENDING) -> header/sub/updated at b+1, busy low at b+1. frame_boundary before PENDING is not remembered.
- Active outputs are registered and stable between swaps; never partially updated.

## Test plan

- Reset, then AVI frame (type 2, version 2, length 13, PB1..PB13 = 02,08,00,01,00, rest 0), SWAP_ON_BOUNDARY=0 -> header = 24'h0D0282, PB0 = 0x64, sub[0] = 56'h00000100080264, sub[1..3] = 0, valid=1, updated one pulse.
- Length 0, type 1, version 1 -> PB0 = 0x7E, header = 24'h000181, swap two cycles after cfg_start.
- cfg_length = 28 -> error pulse, busy stays 0, active frame and valid unchanged.
- SWAP_ON_BOUNDARY=1: complete frame, hold frame_boundary low 100 cycles -> outputs unchanged, busy=1; pulse frame_boundary -> update next cycle. Repeat with abort asserted same cycle as frame_boundary -> no update, IDLE.
- Second frame with shorter length (5) after 13-byte frame -> PB6..PB13 read 0; wr_valid gaps mid-load tolerated, checksum correct.
- reset asserted during LOAD -> all outputs return to reset values next cycle; subsequent frame loads normally.
